ftdi_cmd_parser: RTL

- Downstream consumer of the FTDI controller's receive byte stream, and upstream source of its transmit bytes.
- Replaces the debug byte-invert echo with a small register-access protocol: host writes or reads an on-chip 8-bit register bank.
- Each command receives exactly one reply byte back through the controller.
- Register bank drives board-level controls, e.g. the LED.

---
 rtl/ftdi_proto_pkg.sv | 28 ++
 rtl/ftdi_rx_timeout.sv | 36 +++
 rtl/ftdi_cmd_parser.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ftdi_proto_pkg.sv
// Protocol constants and FSM state encoding shared by the FTDI command parser
// and its testbench.
package ftdi_proto_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] CMD_WR        = 8'h57;
  localparam logic [7:0] CMD_RD        = 8'h52;
  localparam logic [7:0] ACK           = 8'h06;
  localparam logic [7:0] NAK           = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_EXEC,
    ST_SEND_WAIT,
    ST_SEND
  } state_e;

  // Error counter add that sticks at 8'hFF instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/ftdi_rx_timeout.sv
// Inter-byte idle counter: clears on clr_i, counts while en_i, and pulses
// expire_o for one cycle on the terminal count unless clr_i wins that cycle.
module ftdi_rx_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned   CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire_o = en_i && !clr_i && (cnt_q == TERM);
    cnt_d    = cnt_q;
    if (clr_i || expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ftdi_cmd_parser.sv
// Register-access protocol on top of the FTDI byte stream: SYNC/CMD/ADDR[/DATA]
// frames read or write an 8-bit register bank, one reply byte per command.
module ftdi_cmd_parser
  import ftdi_proto_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic [7:0]            in_rx_data,
  input  logic                  in_rx_ready,
  input  logic                  in_tx_busy,
  output logic [7:0]            out_tx_data,
  output logic                  out_tx_ready,
  output logic [8*NUM_REGS-1:0] out_regs,
  output logic [7:0]            out_err_count
);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] reply_q, reply_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] err_q, err_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  logic       expire;
  logic       in_frame;
  logic       addr_ok;
  logic [7:0] rd_val;
  logic       fsm_err;
  logic       drop_err;

  assign in_frame = (state_q == ST_GET_CMD) || (state_q == ST_GET_ADDR) ||
                    (state_q == ST_GET_DATA);

  ftdi_rx_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (in_clk),
    .rst_i    (in_rst),
    .clr_i    (in_rx_ready || (state_q == ST_IDLE)),
    .en_i     (in_frame),
    .expire_o (expire)
  );

  assign addr_ok = (32'(addr_q) < NUM_REGS);

  always_comb begin
    rd_val = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (addr_q == 8'(k)) rd_val = regs_q[k];
    end
  end

  // Bytes arriving while a command executes or its reply is pending are lost.
  assign drop_err = in_rx_ready && ((state_q == ST_EXEC) || (state_q == ST_SEND_WAIT) ||
                                    (state_q == ST_SEND));

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    reply_d   = reply_q;
    tx_data_d = tx_data_q;
    regs_d    = regs_q;
    fsm_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_rx_ready && (in_rx_data == SYNC_BYTE)) state_d = ST_GET_CMD;
      end
      ST_GET_CMD: begin
        if (in_rx_ready) begin
          cmd_d   = in_rx_data;
          state_d = ST_GET_ADDR;
        end else if (expire) begin
          fsm_err = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_GET_ADDR: begin
        if (in_rx_ready) begin
          addr_d  = in_rx_data;
          state_d = (cmd_q == CMD_WR) ? ST_GET_DATA : ST_EXEC;
        end else if (expire) begin
          fsm_err = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (in_rx_ready) begin
          data_d  = in_rx_data;
          state_d = ST_EXEC;
        end else if (expire) begin
          fsm_err = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_SEND_WAIT;
        if ((cmd_q != CMD_WR) && (cmd_q != CMD_RD)) begin
          reply_d = NAK;
          fsm_err = 1'b1;
        end else if (!addr_ok) begin
          reply_d = NAK;
          fsm_err = 1'b1;
        end else if (cmd_q == CMD_WR) begin
          for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (addr_q == 8'(k)) regs_d[k] = data_q;
          end
          reply_d = ACK;
        end else begin
          reply_d = rd_val;
        end
      end
      ST_SEND_WAIT: begin
        if (!in_tx_busy) begin
          tx_data_d = reply_q;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    err_d = sat_add8(err_q, {1'b0, fsm_err} + {1'b0, drop_err});
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      reply_q   <= '0;
      tx_data_q <= '0;
      err_q     <= '0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      reply_q   <= reply_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
      regs_q    <= regs_d;
    end
  end

  // Strobe decoded from the state register so reset removes it asynchronously.
  assign out_tx_ready  = (state_q == ST_SEND);
  assign out_tx_data   = tx_data_q;
  assign out_err_count = err_q;

  always_comb begin
    out_regs = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      out_regs[8*k +: 8] = regs_q[k];
    end
  end

endmodule
